// File: rtl/shift_sched_if.sv
// Request/response bundle for shift_sched: two shift requesters and the
// tagged result channel. The slave side is the scheduler.
interface shift_sched_if #(
  parameter int TAG_W = 1
);
  logic              req0_valid;
  logic              req0_ready;
  logic [31:0]       req0_a;
  logic [4:0]        req0_b;
  logic              req0_aorl;
  logic              req1_valid;
  logic              req1_ready;
  logic [31:0]       req1_a;
  logic [4:0]        req1_b;
  logic              req1_aorl;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic [TAG_W-1:0]  rsp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_aorl,
    output req1_valid, req1_a, req1_b, req1_aorl,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_aorl,
    input  req1_valid, req1_a, req1_b, req1_aorl,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/shift_sched.sv
// shift_sched: two-port scheduler for the shared 32-bit barrel right shifter.
// One shift in flight: IDLE (grant) -> EXEC (shifter sees operands) -> RESP.
// Build option: SHIFT_SCHED_RR_EN selects round-robin arbitration; without it
// requester 0 has fixed priority and no last-grant register exists.
module shift_sched #(
  parameter int TAG_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  shift_sched_if.slave      bus,
  output logic [31:0]       sh_a,
  output logic [4:0]        sh_b,
  output logic              sh_aorl,
  input  logic [31:0]       sh_out,
  output logic              busy,
  output logic [15:0]       ops_done
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [31:0]  op_a_q;
  logic [4:0]   op_b_q;
  logic         op_aorl_q;
  logic         tag_q;
  logic         rsp_valid_q;
  logic [31:0]  rsp_data_q;
  logic [15:0]  ops_done_q;
  logic         gnt, gnt_id, hs;

  // Grant only from IDLE and never while reset is held.
  assign gnt = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;
  assign hs  = (state_q == RESP) && bus.rsp_ready;

`ifdef SHIFT_SCHED_RR_EN
  logic last_q;

  // Winner selection: alternate on contention, otherwise take whoever asks.
  always_comb begin
    gnt_id = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) gnt_id = ~last_q;
  end

  // Remember the most recent grant; moves only when a grant happens.
  always_ff @(posedge clk) begin
    if (rst)      last_q <= 1'b1;
    else if (gnt) last_q <= gnt_id;
  end
`else
  // Fixed priority: requester 1 wins only when requester 0 is idle.
  assign gnt_id = !bus.req0_valid && bus.req1_valid;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request readies and busy flag.
  always_comb begin
    bus.req0_ready = gnt && !gnt_id;
    bus.req1_ready = gnt && gnt_id;
    busy           = (state_q != IDLE);
  end

  // Operand/tag capture on grant, result capture in EXEC, valid until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_aorl_q   <= 1'b0;
      tag_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      if (gnt) begin
        op_a_q    <= gnt_id ? bus.req1_a    : bus.req0_a;
        op_b_q    <= gnt_id ? bus.req1_b    : bus.req0_b;
        op_aorl_q <= gnt_id ? bus.req1_aorl : bus.req0_aorl;
        tag_q     <= gnt_id;
      end
      if (state_q == EXEC) begin
        rsp_data_q  <= sh_out;
        rsp_valid_q <= 1'b1;
      end
      if (hs) rsp_valid_q <= 1'b0;
    end
  end

  // Completed-handshake counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)     ops_done_q <= '0;
    else if (hs) ops_done_q <= ops_done_q + 16'd1;
  end

  // Output wiring; rsp_id carries the requester index in bit 0 only.
  always_comb begin
    sh_a          = op_a_q;
    sh_b          = op_b_q;
    sh_aorl       = op_aorl_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_data  = rsp_data_q;
    bus.rsp_id    = '0;
    bus.rsp_id[0] = tag_q;
    ops_done      = ops_done_q;
  end

endmodule

// File: doc/shift_sched.md
# shift_sched

Two-port scheduler for the shared 32-bit barrel right shifter in the execute stage. Arbitrates between requester 0 (integer pipe) and requester 1 (address/aux unit), drives the shifter's operand and mode inputs from registered values, and returns the result with a requester tag over a valid/ready response channel. Exactly one shift is in flight at a time. The shifter itself stays a separate combinational instance wired to the `sh_*` ports.

## Interface
- `TAG_W`, default 1: width of `rsp_id`. Only bit 0 is meaningful; upper bits are tied 0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` input 1 each: shift request pending.
- `req0_ready` / `req1_ready` output 1 each: request accepted this cycle.
- `req0_a` / `req1_a` input 32 each: value to shift.
- `req0_b` / `req1_b` input 5 each: shift amount.
- `req0_aorl` / `req1_aorl` input 1 each: shifter mode bit; passed through uninterpreted.
- `sh_a` output 32: shifter operand.
- `sh_b` output 5: shifter amount.
- `sh_aorl` output 1: shifter mode.
- `sh_out` input 32: shifter result, combinational from `sh_*`.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer accepts the result.
- `rsp_data` output 32: captured shifter result.
- `rsp_id` output TAG_W: requester index of the result.
- `busy` output 1: high in any state other than IDLE.
- `ops_done` output 16: count of completed response handshakes; wraps 0xFFFF→0x0000.

## Operation
- FSM states are IDLE, EXEC and RESP.
- **IDLE**
  - If no request is valid, stay in IDLE.
  - Otherwise grant one requester and assert its `reqN_ready` combinationally in the same cycle.
  - On the clock edge, latch a/b/aorl into the operand register and the requester index into the tag register, then go to EXEC.
- **EXEC**
  - `sh_*` are driven from the operand register and are stable for the whole cycle.
  - On the edge, capture `sh_out` into `rsp_data`, set `rsp_valid`, and go to RESP.
- **RESP**
  - Hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready`.
  - On the handshake edge: clear `rsp_valid`, increment `ops_done`, go to IDLE.
- Both `reqN_ready` are 0 outside IDLE.
- At most one `reqN_ready` is high in any cycle.
- Requesters must hold valid and operands stable until ready. Dropping valid before grant is legal and loses nothing.
- `sh_*` keep their last operand values in RESP and IDLE; they change only on a grant.
- Arbitration (round-robin build):
  - A `last` register, reset to 1, records the previous grant.
  - When both requests are valid, grant `~last`.
  - When one request is valid, grant it.
  - `last` updates only on a grant.

## Timing
- Reset values:
  - FSM state = IDLE.
  - `req0_ready` = `req1_ready` = 0 during reset.
  - `sh_a` = 0, `sh_b` = 0, `sh_aorl` = 0.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0.
  - `busy` = 0, `ops_done` = 0, `last` = 1.
- Latency: grant at cycle T, `rsp_valid` high from T+2.
- Best-case throughput is one shift per 3 cycles, when `rsp_ready` is held high. The next grant can occur at T+3.
- Reset in EXEC or RESP aborts the operation:
  - No response is produced.
  - `ops_done` does not increment.
- A request presented in the same cycle as the RESP handshake is not granted until the following cycle (IDLE).
- `rsp_ready` outside RESP is ignored.

## Configuration
- `SHIFT_SCHED_RR_EN` defined: round-robin arbitration as described above.
- `SHIFT_SCHED_RR_EN` undefined: fixed priority, requester 0 always wins.
  - The `last` register is not built.
  - Requester 1 can starve under continuous requester-0 traffic.
- All other behaviour and timing are identical in both builds.

## Test plan
The bench shifter stub returns `sh_out = sh_a >> sh_b` (logical), regardless of `sh_aorl`.

- **Single request:** `req0` a=0x80000000, b=4, aorl=0, rsp_ready=1.
  - `req0_ready` is high at T.
  - At T+1: `sh_a`=0x80000000, `sh_b`=4.
  - At T+2: `rsp_valid`=1, `rsp_data`=0x08000000, `rsp_id`=0.
  - At T+3: `ops_done`=1.
- **Simultaneous requests, RR build:** both valid continuously; req0 a=0xF0, req1 a=0xF00, b=4.
  - Responses alternate 0x0F (id 0), 0xF0 (id 1), 0x0F (id 0).
  - Fixed-priority build: every response is id 0.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid` rises.
  - `rsp_data`/`rsp_id` stay constant and both `reqN_ready` stay 0.
  - `busy`=1 throughout.
  - Completes one cycle after `rsp_ready` rises.
- **Reset mid-operation:** assert `rst` in EXEC.
  - Next cycle: `rsp_valid`=0, `busy`=0, `ops_done` unchanged at 0, `sh_a`=0.
- **Counter wrap:** preload via 65535 completed ops (or force).
  - The next handshake gives `ops_done`=0x0000.
- **Zero shift:** b=0, a=0xDEADBEEF.
  - `rsp_data`=0xDEADBEEF with full 2-cycle latency, with no shortcut.
